ui_input_bank: RTL and testbench

Parametrised bank of debounced, edge-detecting user inputs. It replaces the per-pin trigger-smoother instances at the top level with one block of `CHANNELS` channels. Each channel synchronises a raw active-low GPIO pin, debounces it over a configurable window, and reports:

- a clean level;
- one-cycle press and release events;
- hold and auto-repeat events.

A per-channel enable mask lets the state controller ignore keys outside the states that use them. The block feeds MusicBoxStateController and MusicKeysController.

---
 rtl/ui_input_bank.sv | 142 ++++++++++++++
 tb/tb_ui_input_bank.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ui_input_bank.sv
// Bank of synchronised, debounced user inputs with press/release/hold events.
// One shared prescaler provides the hold timebase for every channel.
module ui_input_bank #(
  parameter  int CHANNELS        = 10,
  parameter  int ACTIVE_LOW      = 1,
  parameter  int DEBOUNCE_CYCLES = 50000,
  parameter  int TICK_CYCLES     = 50000,
  parameter  int HOLD_TICKS      = 500,
  parameter  int REPEAT_TICKS    = 100,
  localparam int KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_50Mhz,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] input_raw,
  input  logic [CHANNELS-1:0] enable_mask,
  output logic [CHANNELS-1:0] output_pressed,
  output logic [CHANNELS-1:0] output_pressEvent,
  output logic [CHANNELS-1:0] output_releaseEvent,
  output logic [CHANNELS-1:0] output_holdEvent,
  output logic                output_anyPressed,
  output logic [KW-1:0]       output_keyIndex
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] H_LOAD = (REPEAT_TICKS != 0)
    ? HW'(HOLD_TICKS - REPEAT_TICKS) : HW'(HOLD_TICKS);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_CYCLES - 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [PW-1:0]       pre;
  logic                tick;

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= {CHANNELS{POL}};
      sync2 <= {CHANNELS{POL}};
    end else begin
      sync1 <= input_raw;
      sync2 <= sync1;
    end
  end

  // Free-running: key activity never realigns the tick phase.
  assign tick = (pre == P_LAST);

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic          a;
    logic          s;
    logic          s_nxt;
    logic          pe;
    logic          re;
    logic          he;
    logic [CW-1:0] c;
    logic [CW-1:0] c_nxt;
    logic [HW-1:0] h;

    assign a = sync2[i] ^ POL;

    always_comb begin
      s_nxt = s;
      c_nxt = '0;
      if (a != s) begin
        if (c == C_LAST) begin
          s_nxt = a;
        end else begin
          c_nxt = c + CW'(1);
        end
      end
    end

    // Hold counts only while the key stays down across the edge,
    // so a falling edge can never coincide with a hold pulse.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
        s  <= 1'b0;
        c  <= '0;
        h  <= '0;
        pe <= 1'b0;
        re <= 1'b0;
        he <= 1'b0;
      end else if (!enable_mask[i]) begin
        s  <= 1'b0;
        c  <= '0;
        h  <= '0;
        pe <= 1'b0;
        re <= 1'b0;
        he <= 1'b0;
      end else begin
        s  <= s_nxt;
        c  <= c_nxt;
        pe <= ~s & s_nxt;
        re <= s & ~s_nxt;
        he <= 1'b0;
        if (!(s && s_nxt)) begin
          h <= '0;
        end else if (tick) begin
          if (h == H_LAST) begin
            h  <= H_LOAD;
            he <= 1'b1;
          end else if (h != H_MAX) begin
            h <= h + HW'(1);
          end
        end
      end
    end

    assign output_pressed[i]      = s;
    assign output_pressEvent[i]   = pe;
    assign output_releaseEvent[i] = re;
    assign output_holdEvent[i]    = he;
  end

  assign output_anyPressed = |output_pressed;

  always_comb begin
    output_keyIndex = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (output_pressed[i]) begin
        output_keyIndex = KW'(i);
      end
    end
  end

endmodule

// File: tb/tb_ui_input_bank.sv
// Scoreboard bench for ui_input_bank: model queue checked every cycle,
// plus directed latency / hold / mask measurements.
module tb_ui_input_bank;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int T  = 10;
  localparam int HT = 3;
  localparam int RT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] raw;
  logic [N-1:0] mask;
  logic [N-1:0] pressed;
  logic [N-1:0] press_ev;
  logic [N-1:0] rel_ev;
  logic [N-1:0] hold_ev;
  logic         any;
  logic [1:0]   idx;

  ui_input_bank #(
    .CHANNELS(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES(T), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
  ) dut (
    .clock_50Mhz(clk),
    .reset_n(rst_n),
    .input_raw(raw),
    .enable_mask(mask),
    .output_pressed(pressed),
    .output_pressEvent(press_ev),
    .output_releaseEvent(rel_ev),
    .output_holdEvent(hold_ev),
    .output_anyPressed(any),
    .output_keyIndex(idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] pr;
    logic [N-1:0] pe;
    logic [N-1:0] re;
    logic [N-1:0] he;
    logic         any;
    logic [1:0]   idx;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   started = 0;

  // Reference model: window of the last D synchronised samples,
  // ticks counted since the key went down.
  logic [N-1:0] m_d1, m_d2, m_s;
  int           m_win [N][D];
  int           m_th  [N];
  int           m_e;
  exp_t         mx;

  task automatic m_reset();
    m_d1 = '1;
    m_d2 = '1;
    m_s  = '0;
    m_e  = 0;
    for (int i = 0; i < N; i++) begin
      m_th[i] = 0;
      for (int k = 0; k < D; k++) m_win[i][k] = 2;
    end
  endtask

  task automatic m_step(output exp_t x);
    logic [N-1:0] a;
    logic         sn;
    bit           tk;
    bit           all;
    bit           found;
    m_e++;
    tk = (m_e % T) == 0;
    a = ~m_d2;
    m_d2 = m_d1;
    m_d1 = raw;
    x = '0;
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) begin
        m_s[i] = 1'b0;
        m_th[i] = 0;
        for (int k = 0; k < D; k++) m_win[i][k] = 2;
      end else begin
        for (int k = D - 1; k > 0; k--) m_win[i][k] = m_win[i][k-1];
        m_win[i][0] = int'(a[i]);
        all = 1;
        for (int k = 0; k < D; k++)
          if (m_win[i][k] != int'(!m_s[i])) all = 0;
        sn = all ? ~m_s[i] : m_s[i];
        x.pe[i] = !m_s[i] && sn;
        x.re[i] = m_s[i] && !sn;
        if (m_s[i] && sn) begin
          if (tk) begin
            m_th[i]++;
            if (RT == 0)
              x.he[i] = (m_th[i] == HT);
            else
              x.he[i] = (m_th[i] >= HT) && ((m_th[i] - HT) % RT == 0);
          end
        end else begin
          m_th[i] = 0;
        end
        m_s[i] = sn;
      end
    end
    x.pr = m_s;
    x.any = |m_s;
    found = 0;
    for (int i = 0; i < N; i++) begin
      if (m_s[i] && !found) begin
        x.idx = 2'(i);
        found = 1;
      end
    end
  endtask

  always @(negedge rst_n) begin
    m_reset();
    if (q.size() > 0) q[q.size()-1] = '0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_reset();
      q.push_back('0);
    end else begin
      m_step(mx);
      q.push_back(mx);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (q.size() == 0) begin
      if (started) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty t=%0t no expected entry", $time);
      end
    end else begin
      e = q.pop_front();
      started = 1;
      g = {pressed, press_ev, rel_ev, hold_ev, any, idx};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL scoreboard t=%0t got pr=%b pe=%b re=%b he=%b any=%b idx=%0d expected pr=%b pe=%b re=%b he=%b any=%b idx=%0d",
                 $time, g.pr, g.pe, g.re, g.he, g.any, g.idx,
                 e.pr, e.pe, e.re, e.he, e.any, e.idx);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic sel(input int kind, input int ch);
    case (kind)
      0: return pressed[ch];
      1: return press_ev[ch];
      2: return rel_ev[ch];
      default: return hold_ev[ch];
    endcase
  endfunction

  // Edges until the selected output is seen high; -1 if the bound expires.
  task automatic edges_until(input int ch, input int kind,
                             input int lim, output int n);
    n = -1;
    for (int k = 1; k <= lim; k++) begin
      @(posedge clk);
      #1;
      if (sel(kind, ch)) begin
        n = k;
        break;
      end
    end
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int first;
    int second;
    int ch;
    rst_n = 1'b0;
    raw   = '1;
    mask  = '1;
    cyc(3);
    rst_n = 1'b1;
    cyc(20);

    rst_n = 1'b0;
    cyc(3);
    chk("reset_pressed", int'(pressed), 0);
    chk("reset_key_index", int'(idx), 0);
    chk("reset_any", int'(any), 0);
    rst_n = 1'b1;
    cyc(30);

    raw[1] = 1'b0;
    edges_until(1, 1, 40, n);
    chk("press_latency", n, 10);
    chk("press_level", int'(pressed[1]), 1);
    chk("press_key_index", int'(idx), 1);
    cyc(1);
    chk("press_pulse_width", int'(press_ev[1]), 0);
    raw[1] = 1'b1;
    edges_until(1, 2, 40, n);
    chk("release_latency", n, 10);
    cyc(5);

    raw[0] = 1'b0; cyc(7);
    raw[0] = 1'b1; cyc(1);
    raw[0] = 1'b0; cyc(7);
    raw[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      cnt += int'(pressed[0] | press_ev[0]);
    end
    #1;
    chk("bounce_no_press", cnt, 0);
    raw[0] = 1'b0;
    edges_until(0, 1, 40, n);
    chk("bounce_then_press", n, 10);
    raw[0] = 1'b1;
    cyc(15);

    raw[2] = 1'b0;
    edges_until(2, 1, 40, n);
    chk("hold_press_latency", n, 10);
    first = -1;
    second = -1;
    for (int k = 1; k <= 90; k++) begin
      @(posedge clk);
      #1;
      if (hold_ev[2]) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    #1;
    chk("hold_first_window", int'(first >= 20 && first <= 30), 1);
    chk("hold_repeat_period", second - first, 20);
    raw[2] = 1'b1;
    edges_until(2, 2, 40, n);
    chk("hold_release_seen", int'(n > 0), 1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      cnt += int'(hold_ev[2]);
    end
    #1;
    chk("no_hold_after_release", cnt, 0);

    raw[1] = 1'b0;
    raw[3] = 1'b0;
    edges_until(1, 1, 40, n);
    chk("sim_press_ch1", n, 10);
    chk("sim_press_ch3", int'(press_ev[3]), 1);
    chk("sim_key_index", int'(idx), 1);
    cyc(3);
    mask[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("mask_drops_level", int'(pressed[1]), 0);
    chk("mask_no_release", int'(rel_ev[1]), 0);
    chk("mask_key_index", int'(idx), 3);
    #1;
    cyc(4);
    mask[1] = 1'b1;
    edges_until(1, 1, 40, n);
    chk("unmask_press_latency", n, 8);
    raw[1] = 1'b1;
    raw[3] = 1'b1;
    cyc(20);

    raw[0] = 1'b0;
    cyc(7);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    edges_until(0, 1, 40, n);
    chk("reset_mid_debounce", n, 10);
    raw[0] = 1'b1;
    cyc(15);

    for (int it = 0; it < 80; it++) begin
      ch = $urandom_range(0, N - 1);
      if ($urandom_range(0, 9) == 0) mask[ch] = ~mask[ch];
      else raw[ch] = ~raw[ch];
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) cyc($urandom_range(40, 120));
      else cyc($urandom_range(1, 12));
    end
    raw  = '1;
    mask = '1;
    cyc(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
